// File: rtl/mem_pkg.sv
// Shared state encoding, legal read-latency bounds and a clog2 helper
// for the parametrised single-port memory controller.
package mem_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl_ram.sv
// Inferred single-port synchronous RAM, read-first; 1-cycle read, or 2 with OUT_REG.
// No handshake: a write or read happens on every edge, the controller decides which.
module mem_ctrl_ram
  import mem_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter bit OUT_REG = 1'b1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= din;
    end
    r_q <= r_mem[addr];
  end

  if (OUT_REG) begin : g_oreg
    logic [DATA_W-1:0] r_dout;
    always_ff @(posedge clk) begin
      r_dout <= r_q;
    end
    assign dout = r_dout;
  end else begin : g_noreg
    assign dout = r_q;
  end

endmodule

// File: rtl/mem_ctrl_pipe.sv
// Memory controller: clear sweep after reset/clr, reads return READ_LAT cycles after accept.
// req_ready is low for the whole sweep; once READY every request is accepted immediately.
module mem_ctrl_pipe
  import mem_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 4,
  parameter int                DEPTH       = 16,
  parameter int                READ_LAT    = 2,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              clr,
  output logic              busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err
);

  localparam int                CNT_W    = clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_END  = CNT_W'(DEPTH);
  localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(DEPTH);

  if (READ_LAT < RD_LAT_MIN || READ_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("mem_ctrl_pipe: READ_LAT must be 1 or 2");
  end
  if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("mem_ctrl_pipe: DEPTH exceeds address space");
  end

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [READ_LAT-1:0] r_vld_pipe;
  logic [READ_LAT-1:0] r_err_pipe;
  logic [DATA_W-1:0]   r_hold;

  logic              w_accept;
  logic              w_in_range;
  logic              w_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_din;
  logic [DATA_W-1:0] w_ram_dout;
  logic              w_out_vld;
  logic              w_out_err;

  assign busy       = (r_state == ST_INIT);
  assign req_ready  = (r_state == ST_READY);
  assign w_accept   = req_valid && req_ready;
  assign w_in_range = ({1'b0, req_addr} < ADDR_LIM);

  // The sweep owns the RAM port in INIT; out-of-range writes are dropped here.
  assign w_we       = rst && (busy || (w_accept && req_write && w_in_range));
  assign w_ram_addr = busy ? ADDR_W'(r_cnt) : req_addr;
  assign w_ram_din  = busy ? CLEAR_VALUE : req_wdata;

  mem_ctrl_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .OUT_REG(READ_LAT == RD_LAT_MAX)
  ) u_ram (
    .clk (clk),
    .we  (w_we),
    .addr(w_ram_addr),
    .din (w_ram_din),
    .dout(w_ram_dout)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else if (r_state == ST_INIT) begin
      if (r_cnt != CNT_END) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_cnt == CNT_LAST) begin
        r_state <= ST_READY;
      end
    end else if (clr) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end
  end

  // Valid/err shift alongside the RAM read path so they line up with w_ram_dout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld_pipe <= '0;
      r_err_pipe <= '0;
      r_hold     <= '0;
    end else begin
      r_vld_pipe <= READ_LAT'({r_vld_pipe, w_accept && !req_write});
      r_err_pipe <= READ_LAT'({r_err_pipe, !w_in_range});
      if (w_out_vld) begin
        r_hold <= rd_data;
      end
    end
  end

  assign w_out_vld = r_vld_pipe[READ_LAT-1];
  assign w_out_err = r_err_pipe[READ_LAT-1];
  assign rd_valid  = w_out_vld;
  assign rd_err    = w_out_vld && w_out_err;
  assign rd_data   = !w_out_vld ? r_hold : (w_out_err ? CLEAR_VALUE : w_ram_dout);

endmodule

// File: tb/tb_mem_ctrl_pipe.sv
// Scoreboard bench: instance A uses defaults, instance B uses DEPTH=12, READ_LAT=1, CLEAR_VALUE=0x5A.
module tb_mem_ctrl_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int errors = 0;
  int checks = 0;

  logic       a_rst, a_req_valid, a_req_ready, a_req_write, a_clr, a_busy, a_rd_valid, a_rd_err;
  logic [3:0] a_req_addr;
  logic [7:0] a_req_wdata, a_rd_data;
  logic       b_rst, b_req_valid, b_req_ready, b_req_write, b_clr, b_busy, b_rd_valid, b_rd_err;
  logic [3:0] b_req_addr;
  logic [7:0] b_req_wdata, b_rd_data;

  mem_ctrl_pipe u_a (
    .clk(clk), .rst(a_rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .clr(a_clr), .busy(a_busy),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_err(a_rd_err)
  );

  mem_ctrl_pipe #(.DEPTH(12), .READ_LAT(1), .CLEAR_VALUE(8'h5A)) u_b (
    .clk(clk), .rst(b_rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .clr(b_clr), .busy(b_busy),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_err(b_rd_err)
  );

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (a_rd_valid === 1'b1) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_rd_valid", 1, 0);
      end else begin
        x = qa.pop_front();
        chk("a_rd_data", int'(a_rd_data), int'(x.d));
        chk("a_rd_err", int'(a_rd_err), int'(x.e));
        chk("a_rd_latency_cycle", cyc, x.due);
      end
    end else if (qa.size() != 0 && cyc > qa[0].due) begin
      x = qa.pop_front();
      chk("a_rd_missing", 0, 1);
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (b_rd_valid === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_rd_valid", 1, 0);
      end else begin
        x = qb.pop_front();
        chk("b_rd_data", int'(b_rd_data), int'(x.d));
        chk("b_rd_err", int'(b_rd_err), int'(x.e));
        chk("b_rd_latency_cycle", cyc, x.due);
      end
    end else if (qb.size() != 0 && cyc > qb[0].due) begin
      x = qb.pop_front();
      chk("b_rd_missing", 0, 1);
    end
  end

  task automatic a_wr(input logic [3:0] ad, input logic [7:0] d);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = ad; a_req_wdata = d;
    @(negedge clk);
    a_req_valid = 1'b0; a_req_write = 1'b0;
  endtask

  task automatic a_rd(input logic [3:0] ad, input logic [7:0] d, input logic e, input bit resp);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = ad;
    if (resp) qa.push_back('{d, e, cyc + 2});
    @(negedge clk);
    a_req_valid = 1'b0;
  endtask

  task automatic b_wr(input logic [3:0] ad, input logic [7:0] d);
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = ad; b_req_wdata = d;
    @(negedge clk);
    b_req_valid = 1'b0; b_req_write = 1'b0;
  endtask

  task automatic b_rd(input logic [3:0] ad, input logic [7:0] d, input logic e);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = ad;
    qb.push_back('{d, e, cyc + 1});
    @(negedge clk);
    b_req_valid = 1'b0;
  endtask

  // Counts negedges with busy high; optionally pulses instance A's clr mid-sweep.
  task automatic sweep(input bit use_b, input int pulse_at, output int n);
    n = 0;
    while ((use_b ? b_busy : a_busy) && n < 100) begin
      if (!use_b) a_clr = (n == pulse_at);
      n++;
      @(negedge clk);
    end
    if (!use_b) a_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_rst = 1'b0; a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_clr = 1'b0;
    b_rst = 1'b0; b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_clr = 1'b0;
    fork
      begin : seq_a
        int n;
        repeat (2) @(negedge clk);
        chk("a_reset_busy", int'(a_busy), 1);
        chk("a_reset_req_ready", int'(a_req_ready), 0);
        chk("a_reset_rd_valid", int'(a_rd_valid), 0);
        chk("a_reset_rd_data", int'(a_rd_data), 0);
        chk("a_reset_rd_err", int'(a_rd_err), 0);
        a_rst = 1'b1;
        sweep(1'b0, -1, n);
        chk("a_init_sweep_len", n, 16);
        chk("a_ready_after_sweep", int'(a_req_ready), 1);
        for (int i = 0; i < 16; i++) a_rd(4'(i), 8'h00, 1'b0, 1'b1);
        a_wr(4'd3, 8'hA5);
        a_rd(4'd3, 8'hA5, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) a_wr(4'(i), 8'(16 + i));
        for (int i = 0; i < 4; i++) a_rd(4'(i), 8'(16 + i), 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("a_hold_rd_data", int'(a_rd_data), 8'h13);
        chk("a_hold_rd_valid", int'(a_rd_valid), 0);
        for (int i = 0; i < 16; i++) a_wr(4'(i), 8'hFF);
        a_clr = 1'b1;
        a_rd(4'd5, 8'hFF, 1'b0, 1'b1);
        a_clr = 1'b0;
        chk("a_clr_drops_ready", int'(a_req_ready), 0);
        sweep(1'b0, -1, n);
        chk("a_clr_sweep_len", n, 16);
        a_rd(4'd5, 8'h00, 1'b0, 1'b1);
        a_rd(4'd15, 8'h00, 1'b0, 1'b1);
        a_wr(4'd7, 8'h42);
        a_rd(4'd7, 8'h42, 1'b0, 1'b1);
        a_clr = 1'b1;
        @(negedge clk);
        sweep(1'b0, 4, n);
        chk("a_clr_in_sweep_len", n, 16);
        a_rd(4'd7, 8'h00, 1'b0, 1'b1);
        a_wr(4'd9, 8'h99);
        a_rd(4'd9, 8'h99, 1'b0, 1'b0);
        a_rst = 1'b0;
        @(negedge clk);
        chk("a_rst_cancels_read", int'(a_rd_valid), 0);
        chk("a_rst_busy", int'(a_busy), 1);
        @(negedge clk);
        a_rst = 1'b1;
        sweep(1'b0, -1, n);
        chk("a_rst_sweep_len", n, 16);
        a_rd(4'd9, 8'h00, 1'b0, 1'b1);
      end
      begin : seq_b
        int n;
        repeat (2) @(negedge clk);
        chk("b_reset_busy", int'(b_busy), 1);
        b_rst = 1'b1;
        sweep(1'b1, -1, n);
        chk("b_init_sweep_len", n, 12);
        b_rd(4'd11, 8'h5A, 1'b0);
        b_wr(4'd13, 8'h77);
        b_rd(4'd13, 8'h5A, 1'b1);
        b_wr(4'd3, 8'hA5);
        b_rd(4'd3, 8'hA5, 1'b0);
        b_rd(4'd0, 8'h5A, 1'b0);
        b_wr(4'd11, 8'h3C);
        b_rd(4'd11, 8'h3C, 1'b0);
        b_rd(4'd12, 8'h5A, 1'b1);
        b_rd(4'd15, 8'h5A, 1'b1);
      end
    join
    repeat (5) @(negedge clk);
    chk("a_scoreboard_drained", qa.size(), 0);
    chk("b_scoreboard_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
